// File: rtl/cpu_pkg.sv
// Shared CPU types and register-file size defaults.
// Imported by decode, writeback and the register file.
package cpu_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REGS   = 8;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port.
// Ports: raddr, regs (flattened storage, entry 0 = 0), fwd_en/waddr/wdata
// for same-cycle write forwarding, rdata result.
module regfile_read_port #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 3,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]               raddr,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic                                fwd_en,
  input  logic [ADDR_WIDTH-1:0]               waddr,
  input  logic [DATA_WIDTH-1:0]               wdata,
  output logic [DATA_WIDTH-1:0]               rdata
);

  always_comb begin
    rdata = regs[raddr];
    if (raddr == '0) begin
      rdata = '0;
    end else if (BYPASS && fwd_en && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule

// File: rtl/cpu_registers.sv
// General-purpose register file: r0 hardwired to zero, 2 read ports, 1 write.
// Ports: clk, rst_n, we/waddr/wdata, raddr_a/rdata_a, raddr_b/rdata_b,
// dbg_addr/dbg_data (stored value only, never forwarded).
module cpu_registers
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  logic [DATA_WIDTH-1:0] mem [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic fwd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    regs[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      regs[i] = mem[i];
    end
  end

  // Forwarding is masked in reset so every port reads 0 while rst_n is low.
  assign fwd_en = we & rst_n;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_port_a (
    .raddr  (raddr_a),
    .regs   (regs),
    .fwd_en (fwd_en),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata  (rdata_a)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_port_b (
    .raddr  (raddr_b),
    .regs   (regs),
    .fwd_en (fwd_en),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata  (rdata_b)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (1'b0)
  ) u_port_dbg (
    .raddr  (dbg_addr),
    .regs   (regs),
    .fwd_en (1'b0),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata  (dbg_data)
  );

endmodule

// File: tb/tb_cpu_registers.sv
// Self-checking bench for cpu_registers (BYPASS=1 and BYPASS=0 instances).
// Directed vector table, hand sequences, then random traffic vs a model.
module tb_cpu_registers;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;
  logic [2:0]  dbg_addr;
  logic [15:0] rdata_a, rdata_b, dbg_data;
  logic [15:0] nb_a, nb_b, nb_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] model [8];

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  dbg;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [15:0] exp_dbg;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  cpu_registers #(.BYPASS(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  cpu_registers #(.BYPASS(1'b0)) dut_nb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (nb_a),
    .raddr_b  (raddr_b),
    .rdata_b  (nb_b),
    .dbg_addr (dbg_addr),
    .dbg_data (nb_dbg)
  );

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] a, input bit byp);
    if (a == 3'd0) return 16'h0000;
    if (byp && rst_n && we && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
  endtask

  task automatic drive(input logic w, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [2:0] a,
                       input logic [2:0] b, input logic [2:0] d);
    we = w; waddr = wa; wdata = wd;
    raddr_a = a; raddr_b = b; dbg_addr = d;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a"}, rdata_a, exp_rd(raddr_a, 1'b1));
    chk({tag, "_b"}, rdata_b, exp_rd(raddr_b, 1'b1));
    chk({tag, "_dbg"}, dbg_data, exp_rd(dbg_addr, 1'b0));
    chk({tag, "_nb_a"}, nb_a, exp_rd(raddr_a, 1'b0));
    chk({tag, "_nb_b"}, nb_b, exp_rd(raddr_b, 1'b0));
    chk({tag, "_nb_dbg"}, nb_dbg, exp_rd(dbg_addr, 1'b0));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && we && waddr != 3'd0) model[waddr] = wdata;
    @(negedge clk);
  endtask

  initial begin
    clear_model();
    rst_n = 1'b0;
    drive(1'b1, 3'd1, 16'h4321, 3'd1, 3'd2, 3'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_a", rdata_a, 16'h0000);
    chk("reset_dbg", dbg_data, 16'h0000);
    check_all("reset");
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 3'd0);
    @(negedge clk);

    for (int i = 1; i < 8; i++)
      vecs.push_back('{1'b1, 3'(i), 16'(16'h1111 * i), 3'(i), 3'(i),
                       3'(i), 16'(16'h1111 * i), 16'(16'h1111 * i), 16'h0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{1'b0, 3'd0, 16'h0, 3'(i), 3'(7 - i), 3'(i),
                       16'(16'h1111 * i), 16'(16'h1111 * (7 - i)),
                       16'(16'h1111 * i)});
    vecs.push_back('{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0,
                     16'h0, 16'h0, 16'h0});
    vecs.push_back('{1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0,
                     16'h0, 16'h0, 16'h0});
    vecs.push_back('{1'b1, 3'd2, 16'h1234, 3'd2, 3'd4, 3'd2,
                     16'h1234, 16'h4444, 16'h2222});
    vecs.push_back('{1'b1, 3'd2, 16'h5678, 3'd2, 3'd4, 3'd2,
                     16'h5678, 16'h4444, 16'h1234});
    vecs.push_back('{1'b0, 3'd0, 16'h0, 3'd2, 3'd4, 3'd2,
                     16'h5678, 16'h4444, 16'h5678});
    vecs.push_back('{1'b0, 3'd6, 16'hDEAD, 3'd6, 3'd6, 3'd6,
                     16'h6666, 16'h6666, 16'h6666});
    vecs.push_back('{1'b0, 3'd0, 16'h0, 3'd6, 3'd6, 3'd6,
                     16'h6666, 16'h6666, 16'h6666});

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata,
            vecs[i].ra, vecs[i].rb, vecs[i].dbg);
      #1;
      chk($sformatf("vec%0d_a", i), rdata_a, vecs[i].exp_a);
      chk($sformatf("vec%0d_b", i), rdata_b, vecs[i].exp_b);
      chk($sformatf("vec%0d_dbg", i), dbg_data, vecs[i].exp_dbg);
      check_all($sformatf("vec%0d_m", i));
      tick();
    end

    drive(1'b1, 3'd5, 16'h0001, 3'd0, 3'd0, 3'd0);
    tick();
    drive(1'b1, 3'd5, 16'hA5A5, 3'd5, 3'd5, 3'd5);
    #1;
    chk("byp_a", rdata_a, 16'hA5A5);
    chk("byp_b", rdata_b, 16'hA5A5);
    chk("byp_dbg", dbg_data, 16'h0001);
    chk("nobyp_a", nb_a, 16'h0001);
    chk("nobyp_b", nb_b, 16'h0001);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd5, 3'd5, 3'd5);
    #1;
    chk("byp_next_a", rdata_a, 16'hA5A5);
    chk("byp_next_dbg", dbg_data, 16'hA5A5);
    chk("nobyp_next_a", nb_a, 16'hA5A5);
    chk("nobyp_next_b", nb_b, 16'hA5A5);
    tick();

    drive(1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 3'd0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 3'd3);
    #1;
    chk("pre_rst_a", rdata_a, 16'hBEEF);
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_rst_dbg", dbg_data, 16'h0000);
    chk("async_rst_a", rdata_a, 16'h0000);
    chk("async_rst_nb_a", nb_a, 16'h0000);
    drive(1'b1, 3'd3, 16'h1234, 3'd3, 3'd3, 3'd3);
    #1;
    chk("rst_nofwd_a", rdata_a, 16'h0000);
    chk("rst_nofwd_b", rdata_b, 16'h0000);
    tick();
    chk("rst_wr_dbg", dbg_data, 16'h0000);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd3, 3'd3);
    #1;
    chk("post_rst_dbg", dbg_data, 16'h0000);
    drive(1'b1, 3'd3, 16'h7777, 3'd0, 3'd0, 3'd3);
    tick();
    #1;
    chk("first_wr_dbg", dbg_data, 16'h7777);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        clear_model();
      end else begin
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            16'($urandom), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) raddr_a = waddr;
      if ($urandom_range(0, 3) == 0) raddr_b = waddr;
      #1;
      check_all($sformatf("rnd%0d", i));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_registers.md
# cpu_registers

General-purpose register file for the CPE-CPU datapath: eight 16-bit architectural registers with two combinational read ports feeding the ALU operand muxes and one synchronous write port driven by writeback. Register 0 is hardwired to zero. A third read-only debug port exposes any register to the simulation/trace environment without disturbing the datapath.

## Interface
- Clock `clk` and reset `rst_n`: one clock; reset is asynchronous and active-low.

Parameters:
- `DATA_WIDTH`, default 16: register width in bits.
- `NUM_REGS`, default 8: register count; must be a power of two, at least 2.
- `ADDR_WIDTH`, default $clog2(NUM_REGS) = 3: register index width.
- `BYPASS`, default 1: 1 = write data forwarded to same-cycle reads; 0 = reads return stored value.

Ports:
- `clk`  in  1  system clock, rising edge active.
- `rst_n`  in  1  asynchronous active-low reset.
- `we`  in  1  write enable.
- `waddr`  in  ADDR_WIDTH  write index.
- `wdata`  in  DATA_WIDTH  write data.
- `raddr_a`  in  ADDR_WIDTH  read port A index.
- `rdata_a`  out  DATA_WIDTH  read port A data.
- `raddr_b`  in  ADDR_WIDTH  read port B index.
- `rdata_b`  out  DATA_WIDTH  read port B data.
- `dbg_addr`  in  ADDR_WIDTH  debug read index.
- `dbg_data`  out  DATA_WIDTH  debug read data; never bypassed.

## Operation
- Storage: registers 1..NUM_REGS-1, each DATA_WIDTH bits. Register 0 has no storage.
- Write: on rising `clk`, if `we`=1 and `waddr`≠0, register[`waddr`] <= `wdata`. Writes to index 0 are discarded silently.
- Read A/B: combinational. `rdata_x` = 0 when `raddr_x`=0; else, if BYPASS=1 and `we`=1 and `waddr`=`raddr_x`, `rdata_x` = `wdata`; else the stored value.
- Both read ports may address the same register, including the one being written; each resolves independently by the rule above.
- Debug read: combinational, `dbg_data` = stored register[`dbg_addr`] (0 for index 0); ignores bypass.
- No X propagation: every index in range is valid; no out-of-range case exists since NUM_REGS = 2^ADDR_WIDTH.

## Timing
- Reset: while `rst_n`=0, all stored registers are 0 immediately (asynchronous); reads return 0 on every port; writes are ignored. Deassertion is synchronised externally; first write accepted on the first rising edge with `rst_n`=1.
- Reset asserted mid-write: reset wins; the register holds 0.
- Write latency: data visible in storage (and on non-bypassed/debug reads) the cycle after the write edge. With BYPASS=1, visible combinationally in the same cycle on A/B.
- Read latency: zero cycles (combinational from address, and from `we`/`waddr`/`wdata` when bypassing).
- No handshake; a write every cycle is allowed.

## Structure
- Shared package `cpu_pkg`: `DATA_WIDTH`, `NUM_REGS`, `ADDR_WIDTH` defaults and a `reg_idx_t` typedef used by decode and writeback.
- Single module; read logic for A, B and debug is identical, so one small sub-module `regfile_read_port` (index + bypass enable -> data) instantiated three times is natural (debug with bypass tied off).

## Test plan
- Reset: assert `rst_n`=0 after writing 0xBEEF to r3 -> `dbg_data`, `rdata_a` for r3 read 0x0000 immediately, before any clock edge.
- Write/read all: write r1..r7 with 0x1111*i, then read each on A and B -> values match; r0 reads 0x0000.
- R0 protection: `we`=1, `waddr`=0, `wdata`=0xFFFF -> `rdata_a` (addr 0) and `dbg_data` stay 0x0000.
- Bypass: r5=0x0001 stored; same cycle `we`=1, `waddr`=5, `wdata`=0xA5A5, `raddr_a`=`raddr_b`=5 -> both read 0xA5A5 (BYPASS=1) while `dbg_data`(5)=0x0001; with BYPASS=0 both read 0x0001; next cycle all read 0xA5A5.
- Back-to-back writes: write r2=0x1234 then r2=0x5678 on consecutive edges -> stored 0x5678; r4 unaffected.
- Write disabled: `we`=0 with `waddr`=6, `wdata`=0xDEAD -> r6 unchanged and no bypass on A/B.
